mac_weight_scheduler: RTL and testbench
=======================================

// Module: mac_weight_scheduler
// PURPOSE
//  Weight-load controller for a row of NUM_MACS mac_unit instances.
//  Arbitrates their win_request lines round-robin and fetches each weight from a weight SRAM (1-cycle read latency).
//  Delivers the weight on a shared win bus with a one-hot win_valid.
//  After every unit has received WEIGHTS_PER_MAC weights, raises instr so the array enters compute mode.
// PARAMETERS
//  NUM_MACS         4    number of mac_unit requesters
//  DATA_SIZE        8    weight width, matches array data width
//  ADDR_WIDTH       8    weight SRAM address width; NUM_MACS*WEIGHTS_PER_MAC <= 2**ADDR_WIDTH
//  WEIGHTS_PER_MAC  16   weights loaded into each unit per pass
// PORTS
//  clock        in   1          single clock, rising edge
//  reset        in   1          synchronous, active-high
//  start        in   1          begin a load pass; sampled only in IDLE
//  win_request  in   NUM_MACS   bit i = mac_unit i requests its next weight (level)
//  mem_rd_en    out  1          weight SRAM read enable
//  mem_addr     out  ADDR_WIDTH weight SRAM address
//  mem_rd_data  in   DATA_SIZE  SRAM data, valid the cycle after mem_rd_en
//  win          out  DATA_SIZE  weight bus to all units; 0 when win_valid==0
//  win_valid    out  NUM_MACS   one-hot strobe: unit i captures win
//  busy         out  1          high in every state except IDLE
//  done         out  1          one-cycle pulse at end of pass
//  instr        out  1          compute-mode level to the array
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, all per-unit counters 0, RR pointer last=NUM_MACS-1.
//  FSM states: IDLE, ARB, READ, DELIVER, DONE.
//  IDLE:
//   - start=1 -> ARB.
//   - Clears all counters, sets last=NUM_MACS-1, clears instr.
//  ARB:
//   - eligible[i] = win_request[i] && cnt[i] < WEIGHTS_PER_MAC.
//   - Grant the first eligible unit searching last+1, last+2, ... (mod NUM_MACS).
//   - On a grant: latch g, drive mem_addr = g*WEIGHTS_PER_MAC + cnt[g] and mem_rd_en=1 (both registered, visible in READ) -> READ.
//   - All cnt[i] == WEIGHTS_PER_MAC -> DONE, whether or not any request is pending.
//   - No eligible unit, not all full -> stay in ARB (stall cycle).
//  READ:
//   - mem_rd_en=1 for exactly this cycle -> DELIVER.
//  DELIVER:
//   - win = mem_rd_data, win_valid = 1<<g for exactly this cycle.
//   - cnt[g]++, last=g -> ARB.
//  DONE:
//   - done=1 for this cycle; instr<=1, held until the next accepted start or reset -> IDLE.
//  Latency and throughput:
//   - start sampled at cycle 0: READ at cycle 2, first win_valid at cycle 3.
//   - One weight per 3 cycles when requests are continuous.
//  Boundary rules:
//   - start outside IDLE: ignored.
//   - start and reset in the same cycle: reset wins.
//   - A request dropped after grant does not cancel delivery; the granted unit still gets its weight.
//   - A unit whose count is full is never granted again even if it keeps requesting.
//   - Counter width clog2(WEIGHTS_PER_MAC+1); counters never wrap.
//   - Reset mid-pass: immediate return to reset values; the partial pass is discarded.
//   - The next pass restarts at address 0.
// CONFIGURATION
//  MAC_SCHED_PERF_EN defined:
//   - Adds port stall_cycles, out, 16 bits.
//   - Counts ARB cycles with no grant and not all-full.
//   - Saturates at 16'hFFFF; cleared to 0 on reset and on an accepted start; holds its value in IDLE.
//  MAC_SCHED_PERF_EN undefined:
//   - Port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset held 2 cycles, start=1 -> all outputs 0, busy=0, start ignored during reset.
//  2. win_request=4'b1111 continuously, start pulse at cycle 0:
//     - win_valid order 0001,0010,0100,1000,0001,... at cycles 3,6,9,...
//     - mem_addr sequence 0,16,32,48,1,17,...
//     - Last delivery at cycle 192, done=1 at cycle 194, instr=1 from cycle 195, busy=0 at cycle 195.
//  3. win_request=4'b0100 only:
//     - 16 deliveries to unit 2 at addresses 32..47.
//     - Then busy stays 1, done never fires, stall_cycles (PERF_EN) increments every cycle.
//     - Raising the remaining requests completes the pass.
//  4. win_request=4'b1111, reset asserted after 5th win_valid:
//     - Next cycle all outputs 0.
//     - A new start re-delivers from mem_addr 0 to unit 0.
//  5. start pulses during READ/DELIVER are ignored (no counter clear).
//     A start after done clears instr the next cycle and restarts the pass.
//  6. Unit 1 drops win_request for 10 cycles mid-pass:
//     - RR skips it (0,2,3,0,...) and resumes it when reasserted.
//     - Final per-unit counts are all 16 and each address 0..63 is read exactly once.

Source files
------------

// File: rtl/mac_weight_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mac_weight_scheduler_if                                       |
// | Brief    : Start/request, weight-SRAM and win-bus signals of the         |
// |            weight scheduler. stall_cycles exists with MAC_SCHED_PERF_EN. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mac_weight_scheduler_if #(
   parameter int NUM_MACS   = 4,
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic [NUM_MACS-1:0]   win_request;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_SIZE-1:0]  mem_rd_data;
   logic [DATA_SIZE-1:0]  win;
   logic [NUM_MACS-1:0]   win_valid;
   logic                  busy;
   logic                  done;
   logic                  instr;
`ifdef MAC_SCHED_PERF_EN
   logic [15:0]           stall_cycles;

   modport master (
      input  start, win_request, mem_rd_data,
      output mem_rd_en, mem_addr, win, win_valid, busy, done, instr, stall_cycles
   );
   modport slave (
      output start, win_request, mem_rd_data,
      input  mem_rd_en, mem_addr, win, win_valid, busy, done, instr, stall_cycles
   );
`else
   modport master (
      input  start, win_request, mem_rd_data,
      output mem_rd_en, mem_addr, win, win_valid, busy, done, instr
   );
   modport slave (
      output start, win_request, mem_rd_data,
      input  mem_rd_en, mem_addr, win, win_valid, busy, done, instr
   );
`endif
endinterface
`default_nettype wire

// File: rtl/mac_weight_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mac_weight_scheduler                                          |
// | Brief    : Round-robin weight loader for a row of mac units; optional    |
// |            stall counter enabled by the MAC_SCHED_PERF_EN macro.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mac_weight_scheduler #(
   parameter int NUM_MACS        = 4,
   parameter int DATA_SIZE       = 8,
   parameter int ADDR_WIDTH      = 8,
   parameter int WEIGHTS_PER_MAC = 16
) (
   input wire logic               clk,
   input wire logic               rst,
   mac_weight_scheduler_if.master bus
);
   localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
   localparam int CNT_W = $clog2(WEIGHTS_PER_MAC + 1);
   localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(WEIGHTS_PER_MAC);
   localparam logic [IDX_W-1:0] c_last_init = IDX_W'(NUM_MACS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_READ    = 3'd2,
      S_DELIVER = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt [NUM_MACS];
   logic [IDX_W-1:0]      r_last;
   logic [IDX_W-1:0]      r_g;
   logic                  r_mem_rd_en;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_instr;

   logic [NUM_MACS-1:0]   w_full;
   logic [NUM_MACS-1:0]   w_eligible;
   logic                  w_all_full;
   logic                  w_grant_ok;
   logic [IDX_W-1:0]      w_grant_idx;
   logic [IDX_W-1:0]      w_cand;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_SIZE-1:0]  w_win;
   logic [NUM_MACS-1:0]   w_win_valid;
   logic                  w_busy;
   logic                  w_done;

   for (genvar gi = 0; gi < NUM_MACS; gi++) begin : g_unit
      assign w_full[gi]     = (r_cnt[gi] == c_cnt_full);
      assign w_eligible[gi] = bus.win_request[gi] && !w_full[gi];
   end

   assign w_all_full = &w_full;

   // Search starts one past the last served unit so every requester gets a turn.
   always_comb begin
      w_grant_ok  = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int k = 0; k < NUM_MACS; k++) begin
         w_cand = IDX_W'((int'(r_last) + k + 1) % NUM_MACS);
         if (!w_grant_ok && w_eligible[w_cand]) begin
            w_grant_ok  = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   assign w_mem_addr = ADDR_WIDTH'(int'(w_grant_idx) * WEIGHTS_PER_MAC
                                   + int'(r_cnt[w_grant_idx]));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_win       = '0;
      w_win_valid = '0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_state_nxt = S_ARB;
         end
         S_ARB: begin
            if (w_all_full)      w_state_nxt = S_DONE;
            else if (w_grant_ok) w_state_nxt = S_READ;
         end
         S_READ: w_state_nxt = S_DELIVER;
         S_DELIVER: begin
            w_win       = bus.mem_rd_data;
            w_win_valid = NUM_MACS'(1) << r_g;
            w_state_nxt = S_ARB;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read strobe and address live for exactly the READ cycle; zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_MACS; i++) r_cnt[i] <= '0;
         r_last      <= c_last_init;
         r_g         <= '0;
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= '0;
         r_instr     <= 1'b0;
      end else begin
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= '0;
         case (r_state)
            S_IDLE: begin
               for (int i = 0; i < NUM_MACS; i++) r_cnt[i] <= '0;
               r_last <= c_last_init;
               if (bus.start) r_instr <= 1'b0;
            end
            S_ARB: begin
               if (!w_all_full && w_grant_ok) begin
                  r_g         <= w_grant_idx;
                  r_mem_rd_en <= 1'b1;
                  r_mem_addr  <= w_mem_addr;
               end
            end
            S_DELIVER: begin
               r_cnt[r_g] <= r_cnt[r_g] + CNT_W'(1);
               r_last     <= r_g;
            end
            S_DONE: r_instr <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef MAC_SCHED_PERF_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_stall <= '0;
      end else if (r_state == S_ARB && !w_grant_ok && !w_all_full && r_stall != 16'hFFFF) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign bus.stall_cycles = r_stall;
`endif

   assign bus.mem_rd_en = r_mem_rd_en;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.win       = w_win;
   assign bus.win_valid = w_win_valid;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.instr     = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_mac_weight_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mac_weight_scheduler                                       |
// | Brief    : Self-checking bench: timing table, directed corner sequences  |
// |            and random traffic against a transaction-level model.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mac_weight_scheduler;
   localparam int N  = 4;
   localparam int DS = 8;
   localparam int AW = 8;
   localparam int W  = 16;

   logic clk;
   logic rst;

   mac_weight_scheduler_if #(.NUM_MACS(N), .DATA_SIZE(DS), .ADDR_WIDTH(AW)) bus ();

   mac_weight_scheduler #(
      .NUM_MACS(N), .DATA_SIZE(DS), .ADDR_WIDTH(AW), .WEIGHTS_PER_MAC(W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DS-1:0] mem [256];
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Transaction-level model: expected events keyed by absolute cycle.
   bit m_valid = 0;
   bit m_run   = 0;
   int m_pstart = 0, m_pend = -1, m_ifrom = -1, m_ito = -1;
   int m_arb_at = 0, m_last = N - 1, m_stall = 0;
   int m_cnt [N];
   int e_rd [int];
   int e_unit [int];
   int e_data [int];
   bit e_done [int];
   int obs_hits [256];
   int obs_unit [N];

   function automatic bit m_busy(int c);
      return m_run && c >= m_pstart && (m_pend < 0 || c < m_pend);
   endfunction

   function automatic bit m_instr(int c);
      return m_ifrom >= 0 && c >= m_ifrom && (m_ito < 0 || c < m_ito);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] wv;
      logic [DS-1:0] wd;
      if (!m_valid) return;
      wv = e_unit.exists(cyc) ? N'(1) << e_unit[cyc] : '0;
      wd = e_unit.exists(cyc) ? DS'(e_data[cyc]) : '0;
      chk("win_valid", bus.win_valid, wv);
      chk("win", bus.win, wd);
      chk("mem_rd_en", bus.mem_rd_en, e_rd.exists(cyc));
      if (e_rd.exists(cyc)) chk("mem_addr", bus.mem_addr, e_rd[cyc]);
      chk("done", bus.done, e_done.exists(cyc));
      chk("busy", bus.busy, m_busy(cyc));
      chk("instr", bus.instr, m_instr(cyc));
`ifdef MAC_SCHED_PERF_EN
      chk("stall_cycles", bus.stall_cycles, m_stall);
`endif
      if (bus.mem_rd_en === 1'b1) obs_hits[bus.mem_addr]++;
      for (int u = 0; u < N; u++) if (bus.win_valid[u] === 1'b1) obs_unit[u]++;
      e_rd.delete(cyc);
      e_unit.delete(cyc);
      e_data.delete(cyc);
      e_done.delete(cyc);
   endtask

   task automatic model_step(input logic r, input logic s, input logic [N-1:0] req);
      int c = cyc;
      int g, a;
      if (r) begin
         m_valid = 1; m_run = 0; m_pend = -1; m_ifrom = -1; m_ito = -1;
         m_stall = 0; m_last = N - 1;
         for (int u = 0; u < N; u++) m_cnt[u] = 0;
         e_rd.delete(); e_unit.delete(); e_data.delete(); e_done.delete();
         return;
      end
      if (!m_busy(c)) begin
         if (s) begin
            m_run = 1; m_pstart = c + 1; m_pend = -1; m_arb_at = c + 1;
            if (m_ifrom >= 0) m_ito = c + 1;
            m_stall = 0; m_last = N - 1;
            for (int u = 0; u < N; u++) m_cnt[u] = 0;
         end
      end else if (c == m_arb_at) begin
         if (m_cnt[0] == W && m_cnt[1] == W && m_cnt[2] == W && m_cnt[3] == W) begin
            e_done[c + 1] = 1;
            m_pend  = c + 2;
            m_ifrom = c + 2;
            m_ito   = -1;
         end else begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
               if (g < 0 && req[(m_last + k) % N] && m_cnt[(m_last + k) % N] < W)
                  g = (m_last + k) % N;
            end
            if (g >= 0) begin
               a = g * W + m_cnt[g];
               e_rd[c + 1]   = a;
               e_unit[c + 2] = g;
               e_data[c + 2] = int'(mem[a]);
               m_cnt[g]++;
               m_last   = g;
               m_arb_at = c + 3;
            end else begin
               if (m_stall < 65535) m_stall++;
               m_arb_at = c + 1;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic [N-1:0] req);
      check_outputs();
      rst = r;
      bus.start = s;
      bus.win_request = req;
      model_step(r, s, req);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_idle(input logic [N-1:0] req, input int limit);
      for (int k = 0; k < limit; k++) begin
         if (!m_busy(cyc)) break;
         cycle(1'b0, 1'b0, req);
      end
      n_checks++;
      if (m_busy(cyc)) begin
         n_fail++;
         $display("FAIL pass_timeout cyc=%0d actual=busy required=idle", cyc);
      end
   endtask

   typedef struct {
      int          k;
      logic [N-1:0] wv;
      logic        rd;
      logic [AW-1:0] addr;
      logic        done;
      logic        busy;
      logic        instr;
   } vec_t;

   vec_t tbl [17];

   initial begin
      tbl[0]  = '{0,   4'b0000, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1,   4'b0000, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[2]  = '{2,   4'b0000, 1'b1, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[3]  = '{3,   4'b0001, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[4]  = '{5,   4'b0000, 1'b1, 8'd16, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{6,   4'b0010, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[6]  = '{8,   4'b0000, 1'b1, 8'd32, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{9,   4'b0100, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[8]  = '{11,  4'b0000, 1'b1, 8'd48, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{12,  4'b1000, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[10] = '{14,  4'b0000, 1'b1, 8'd1,  1'b0, 1'b1, 1'b0};
      tbl[11] = '{15,  4'b0001, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[12] = '{191, 4'b0000, 1'b1, 8'd63, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{192, 4'b1000, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[14] = '{193, 4'b0000, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
      tbl[15] = '{194, 4'b0000, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0};
      tbl[16] = '{195, 4'b0000, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = DS'($urandom);
      for (int u = 0; u < N; u++) m_cnt[u] = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.win_request = '0;
      @(negedge clk);

      // Reset held two cycles with start high: start must be ignored.
      cycle(1'b1, 1'b1, 4'hF);
      cycle(1'b1, 1'b1, 4'hF);
      chk("t1_busy", bus.busy, 0);
      chk("t1_win_valid", bus.win_valid, 0);
      chk("t1_mem_rd_en", bus.mem_rd_en, 0);
      chk("t1_mem_addr", bus.mem_addr, 0);
      chk("t1_instr", bus.instr, 0);
      cycle(1'b0, 1'b0, 4'h0);

      // Full pass timing with continuous requests.
      for (int k = 0; k <= 196; k++) begin
         for (int i = 0; i < 17; i++) begin
            if (tbl[i].k == k) begin
               chk("t2_win_valid", bus.win_valid, tbl[i].wv);
               chk("t2_mem_rd_en", bus.mem_rd_en, tbl[i].rd);
               if (tbl[i].rd) chk("t2_mem_addr", bus.mem_addr, tbl[i].addr);
               chk("t2_done", bus.done, tbl[i].done);
               chk("t2_busy", bus.busy, tbl[i].busy);
               chk("t2_instr", bus.instr, tbl[i].instr);
            end
         end
         cycle(1'b0, k == 0, 4'hF);
      end

      // Single requester: fills, then stalls until the others request.
      cycle(1'b1, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 4'b0100);
      repeat (70) cycle(1'b0, 1'b0, 4'b0100);
      chk("t3_busy_held", bus.busy, 1);
      chk("t3_done_low", bus.done, 0);
`ifdef MAC_SCHED_PERF_EN
      chk("t3_stall_nonzero", bus.stall_cycles != 16'd0, 1);
`endif
      run_until_idle(4'hF, 400);

      // Reset right after the fifth delivery, then restart from address 0.
      cycle(1'b1, 1'b0, 4'h0);
      for (int k = 0; k <= 15; k++) cycle(1'b0, k == 0, 4'hF);
      cycle(1'b1, 1'b0, 4'hF);
      chk("t4_win_valid", bus.win_valid, 0);
      chk("t4_busy", bus.busy, 0);
      chk("t4_mem_rd_en", bus.mem_rd_en, 0);
      cycle(1'b0, 1'b1, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      chk("t4_restart_rd", bus.mem_rd_en, 1);
      chk("t4_restart_addr", bus.mem_addr, 0);
      run_until_idle(4'hF, 400);

      // Start pulses mid-pass are ignored; start after done clears instr.
      cycle(1'b0, 1'b1, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      cycle(1'b0, 1'b1, 4'hF);
      cycle(1'b0, 1'b1, 4'hF);
      run_until_idle(4'hF, 400);
      chk("t5_instr_set", bus.instr, 1);
      cycle(1'b0, 1'b1, 4'hF);
      chk("t5_instr_cleared", bus.instr, 0);
      run_until_idle(4'hF, 400);

      // Unit 1 drops out for ten cycles mid-pass.
      cycle(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 256; i++) obs_hits[i] = 0;
      for (int u = 0; u < N; u++) obs_unit[u] = 0;
      cycle(1'b0, 1'b1, 4'hF);
      repeat (30) cycle(1'b0, 1'b0, 4'hF);
      repeat (10) cycle(1'b0, 1'b0, 4'b1101);
      run_until_idle(4'hF, 400);
      for (int a = 0; a < N * W; a++) chk("t6_addr_once", obs_hits[a], 1);
      for (int u = 0; u < N; u++) chk("t6_unit_count", obs_unit[u], W);

      // Random traffic with sporadic starts and rare resets.
      for (int k = 0; k < 4000; k++) begin
         cycle($urandom_range(0, 999) == 0, $urandom_range(0, 7) == 0,
               N'($urandom | $urandom));
      end
      run_until_idle(4'hF, 600);
      cycle(1'b0, 1'b0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
